// File: rtl/fpu_csr_unit.sv
// FP control/status registers: frm and sticky fflags, dynamic rounding-mode
// resolution, writeback flag accumulation and CSRRW/CSRRS/CSRRC servicing.
module fpu_csr_unit #(
  parameter logic [11:0] ADDR_FFLAGS = 12'h001,
  parameter logic [11:0] ADDR_FRM    = 12'h002,
  parameter logic [11:0] ADDR_FCSR   = 12'h003
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  inst_rm,
  output logic [2:0]  rm_out,
  output logic        rm_illegal,
  input  logic        wb_valid,
  input  logic [4:0]  wb_flags,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic        csr_hit,
  output logic [31:0] csr_rdata,
  output logic [2:0]  frm_out,
  output logic [4:0]  fflags_out
);

  localparam logic [1:0] OpNone  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpSet   = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  logic [2:0] frm_q, frm_d;
  logic [4:0] fflags_q, fflags_d;
  logic [4:0] acc;
  logic       sel_fflags, sel_frm, sel_fcsr;
  logic [7:0] old_val, new_val;

  assign rm_out     = (inst_rm == 3'b111) ? frm_q : inst_rm;
  assign rm_illegal = (rm_out == 3'b101) || (rm_out == 3'b110) || (rm_out == 3'b111);

  // Retiring FP op is older than a same-cycle CSR op, so its flags land first.
  assign acc = fflags_q | (wb_valid ? wb_flags : 5'b0);

  assign sel_fflags = (csr_op != OpNone) && (csr_addr == ADDR_FFLAGS);
  assign sel_frm    = (csr_op != OpNone) && (csr_addr == ADDR_FRM);
  assign sel_fcsr   = (csr_op != OpNone) && (csr_addr == ADDR_FCSR);
  assign csr_hit    = sel_fflags || sel_frm || sel_fcsr;

  always_comb begin
    old_val = 8'h00;
    if (sel_fflags) begin
      old_val = {3'b000, acc};
    end else if (sel_frm) begin
      old_val = {5'b00000, frm_q};
    end else if (sel_fcsr) begin
      old_val = {frm_q, acc};
    end
  end

  assign csr_rdata = {24'h000000, old_val};

  // Only the low 8 bits of the operand can reach implemented state.
  always_comb begin
    new_val = old_val;
    case (csr_op)
      OpWrite: new_val = csr_wdata[7:0];
      OpSet:   new_val = old_val | csr_wdata[7:0];
      OpClear: new_val = old_val & ~csr_wdata[7:0];
      default: new_val = old_val;
    endcase
  end

  always_comb begin
    frm_d    = frm_q;
    fflags_d = acc;
    if (sel_fflags) begin
      fflags_d = new_val[4:0];
    end else if (sel_frm) begin
      frm_d = new_val[2:0];
    end else if (sel_fcsr) begin
      frm_d    = new_val[7:5];
      fflags_d = new_val[4:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frm_q    <= 3'b000;
      fflags_q <= 5'b00000;
    end else begin
      frm_q    <= frm_d;
      fflags_q <= fflags_d;
    end
  end

  assign frm_out    = frm_q;
  assign fflags_out = fflags_q;

endmodule
